bcd_time_keeper: RTL and testbench

//  Downstream consumer of the clock divider's clk_div output (1 Hz at default rates).

---
 rtl/bcd_time_keeper_if.sv | 27 ++
 rtl/bcd_time_keeper.sv | 127 ++++++++++++
 tb/tb_bcd_time_keeper.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_time_keeper_if.sv
// Bundle of the tick input, enable, preset bus and time/status outputs of bcd_time_keeper.
interface bcd_time_keeper_if;
  logic       clk_div;
  logic       enable;
  logic       load;
  logic [7:0] load_hour;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic [7:0] hour;
  logic [7:0] min;
  logic [7:0] sec;
  logic       sec_tick;
  logic       rollover;
  logic       load_err;

  // Producer side: supplies the divided clock, enable and the preset bus.
  modport master (
    output clk_div, enable, load, load_hour, load_min, load_sec,
    input  hour, min, sec, sec_tick, rollover, load_err
  );

  // Time keeper side: consumes the inputs and drives the BCD time and pulses.
  modport slave (
    input  clk_div, enable, load, load_hour, load_min, load_sec,
    output hour, min, sec, sec_tick, rollover, load_err
  );
endinterface

// File: rtl/bcd_time_keeper.sv
// BCD hh:mm:ss time keeper. Treats clk_div as asynchronous data, synchronises it into
// the fpga_clk domain, and counts one second per detected rising edge. Also accepts a
// validated time preset; invalid presets are rejected with a one-cycle load_err pulse.
module bcd_time_keeper #(
  parameter int SYNC_STAGES = 2,
  parameter int HOUR_MOD    = 24
) (
  input  logic             fpga_clk,
  input  logic             rst,
  bcd_time_keeper_if.slave bus
);

  // Last valid hour in BCD form: 8'h23 for a 24-hour clock, 8'h11 for a 12-hour clock.
  localparam logic [7:0] HOUR_MAX = {4'((HOUR_MOD - 1) / 10), 4'((HOUR_MOD - 1) % 10)};

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   tick;
  logic                   tick_q;

  logic [7:0] hour_q, min_q, sec_q;
  logic       sec_tick_q, rollover_q, load_err_q;

  logic [7:0] hour_n, min_n, sec_n;
  logic       sec_tick_n, rollover_n, load_err_n;
  logic       load_ok;

  // Increment a BCD value with a units carry into the tens digit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {4'(v[7:4] + 4'd1), 4'd0};
    else                r = {v[7:4], 4'(v[3:0] + 4'd1)};
    return r;
  endfunction

  // A minutes/seconds value is legal when units <= 9 and tens <= 5.
  function automatic logic sexagesimal_ok(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5);
  endfunction

  // With both digits in 0..9, BCD values order the same as plain binary, so a byte
  // compare against HOUR_MAX is a correct "hour < HOUR_MOD" test.
  function automatic logic hour_ok(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= HOUR_MAX);
  endfunction

  assign tick    = sync[SYNC_STAGES-1] & ~prev;
  assign load_ok = hour_ok(bus.load_hour) && sexagesimal_ok(bus.load_min) &&
                   sexagesimal_ok(bus.load_sec);

  // Synchroniser chain, edge history and a one-stage tick pipeline; prev tracks every cycle.
  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      sync   <= '0;
      prev   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], bus.clk_div};
      prev   <= sync[SYNC_STAGES-1];
      tick_q <= tick;
    end
  end

  // Next time value: a load wins over a tick, and all carries resolve in one cycle.
  always_comb begin
    hour_n     = hour_q;
    min_n      = min_q;
    sec_n      = sec_q;
    sec_tick_n = 1'b0;
    rollover_n = 1'b0;
    load_err_n = 1'b0;
    if (bus.load) begin
      if (load_ok) begin
        hour_n = bus.load_hour;
        min_n  = bus.load_min;
        sec_n  = bus.load_sec;
      end else begin
        load_err_n = 1'b1;
      end
    end else if (tick_q && bus.enable) begin
      sec_tick_n = 1'b1;
      if (sec_q == 8'h59) begin
        sec_n = 8'h00;
        if (min_q == 8'h59) begin
          min_n = 8'h00;
          if (hour_q == HOUR_MAX) begin
            hour_n     = 8'h00;
            rollover_n = 1'b1;
          end else begin
            hour_n = bcd_inc(hour_q);
          end
        end else begin
          min_n = bcd_inc(min_q);
        end
      end else begin
        sec_n = bcd_inc(sec_q);
      end
    end
  end

  // Time and status registers; reset overrides both load and tick.
  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      hour_q     <= 8'h00;
      min_q      <= 8'h00;
      sec_q      <= 8'h00;
      sec_tick_q <= 1'b0;
      rollover_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      hour_q     <= hour_n;
      min_q      <= min_n;
      sec_q      <= sec_n;
      sec_tick_q <= sec_tick_n;
      rollover_q <= rollover_n;
      load_err_q <= load_err_n;
    end
  end

  assign bus.hour     = hour_q;
  assign bus.min      = min_q;
  assign bus.sec      = sec_q;
  assign bus.sec_tick = sec_tick_q;
  assign bus.rollover = rollover_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Directed self-checking bench for bcd_time_keeper: a 24-hour instance and a 12-hour
// instance share the clock, reset and clk_div stimulus.
module tb_bcd_time_keeper;

  logic fpga_clk;
  logic rst;
  logic cd;
  int   checks;
  int   failures;

  bcd_time_keeper_if if24 ();
  bcd_time_keeper_if if12 ();

  assign if24.clk_div = cd;
  assign if12.clk_div = cd;

  bcd_time_keeper #(.SYNC_STAGES(2), .HOUR_MOD(24)) dut24 (
    .fpga_clk (fpga_clk),
    .rst      (rst),
    .bus      (if24.slave)
  );

  bcd_time_keeper #(.SYNC_STAGES(2), .HOUR_MOD(12)) dut12 (
    .fpga_clk (fpga_clk),
    .rst      (rst),
    .bus      (if12.slave)
  );

  // Free-running system clock, 10 ns period.
  initial begin
    fpga_clk = 1'b0;
    forever #5 fpga_clk = ~fpga_clk;
  end

  // Advance to just after the next rising edge; outputs are sampled and inputs driven here.
  task automatic step();
    @(posedge fpga_clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_time24(input string tag, input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s, input logic tk, input logic ro,
                              input logic er);
    check_val({tag, ".hour"}, if24.hour, h);
    check_val({tag, ".min"}, if24.min, m);
    check_val({tag, ".sec"}, if24.sec, s);
    check_val({tag, ".sec_tick"}, {7'd0, if24.sec_tick}, {7'd0, tk});
    check_val({tag, ".rollover"}, {7'd0, if24.rollover}, {7'd0, ro});
    check_val({tag, ".load_err"}, {7'd0, if24.load_err}, {7'd0, er});
  endtask

  task automatic check_time12(input string tag, input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s, input logic tk, input logic ro,
                              input logic er);
    check_val({tag, ".hour"}, if12.hour, h);
    check_val({tag, ".min"}, if12.min, m);
    check_val({tag, ".sec"}, if12.sec, s);
    check_val({tag, ".sec_tick"}, {7'd0, if12.sec_tick}, {7'd0, tk});
    check_val({tag, ".rollover"}, {7'd0, if12.rollover}, {7'd0, ro});
    check_val({tag, ".load_err"}, {7'd0, if12.load_err}, {7'd0, er});
  endtask

  // Raise clk_div and run to the edge where the count lands (first sample + 3 edges).
  task automatic rise();
    cd = 1'b1;
    repeat (4) step();
  endtask

  // Drop clk_div and let the synchroniser and edge history settle low.
  task automatic fall();
    cd = 1'b0;
    repeat (3) step();
  endtask

  task automatic load24(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    if24.load      = 1'b1;
    if24.load_hour = h;
    if24.load_min  = m;
    if24.load_sec  = s;
    step();
    if24.load = 1'b0;
  endtask

  task automatic load12(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    if12.load      = 1'b1;
    if12.load_hour = h;
    if12.load_min  = m;
    if12.load_sec  = s;
    step();
    if12.load = 1'b0;
  endtask

  // Directed test sequence.
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    cd       = 1'b0;
    if24.enable = 1'b1;  if24.load = 1'b0;
    if24.load_hour = 8'h00; if24.load_min = 8'h00; if24.load_sec = 8'h00;
    if12.enable = 1'b0;  if12.load = 1'b0;
    if12.load_hour = 8'h00; if12.load_min = 8'h00; if12.load_sec = 8'h00;
    #1;

    // T1: reset held while clk_div toggles
    step();
    cd = 1'b1;
    step();
    check_time24("t1_rst_a", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    cd = 1'b0;
    step();
    check_time24("t1_rst_b", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (4) step();
    check_time24("t1_after", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check_time12("t1_after12", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // T2: latency of exactly three edges after first sample, then no repeat while high
    cd = 1'b1;
    step();
    check_time24("t2_n", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    check_time24("t2_n1", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    check_time24("t2_n2", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    check_time24("t2_n3", 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      check_val("t2_hold_tick", {7'd0, if24.sec_tick}, 8'h00);
    end
    check_val("t2_hold_sec", if24.sec, 8'h01);
    fall();

    // T3: full wrap 23:59:58 -> 23:59:59 -> 00:00:00
    load24(8'h23, 8'h59, 8'h58);
    check_time24("t3_load", 8'h23, 8'h59, 8'h58, 1'b0, 1'b0, 1'b0);
    rise();
    check_time24("t3_59", 8'h23, 8'h59, 8'h59, 1'b1, 1'b0, 1'b0);
    fall();
    rise();
    check_time24("t3_wrap", 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    step();
    check_time24("t3_pulse_end", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    fall();

    // Minute and hour carry on the 24-hour instance: 09:59:59 -> 10:00:00
    load24(8'h09, 8'h59, 8'h59);
    rise();
    check_time24("carry_hour", 8'h10, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    fall();
    load24(8'h14, 8'h29, 8'h59);
    rise();
    check_time24("carry_min", 8'h14, 8'h30, 8'h00, 1'b1, 1'b0, 1'b0);
    fall();

    // T4: 12-hour instance wraps at 11:59:59 and rejects hour 12
    if24.enable = 1'b0;
    if12.enable = 1'b1;
    load12(8'h11, 8'h59, 8'h59);
    check_time12("t4_load", 8'h11, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0);
    rise();
    check_time12("t4_wrap", 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    fall();
    load12(8'h12, 8'h30, 8'h00);
    check_time12("t4_bad_hour", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    step();
    check_time12("t4_err_end", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    if12.enable = 1'b0;
    if24.enable = 1'b1;
    load24(8'h24, 8'h00, 8'h00);
    check_time24("t4_bad_hour24", 8'h14, 8'h30, 8'h00, 1'b0, 1'b0, 1'b1);

    // T5: bad digits rejected; load coincident with a tick wins
    load24(8'h10, 8'h6A, 8'h00);
    check_time24("t5_bad_digit", 8'h14, 8'h30, 8'h00, 1'b0, 1'b0, 1'b1);
    load24(8'h10, 8'h60, 8'h00);
    check_time24("t5_min60", 8'h14, 8'h30, 8'h00, 1'b0, 1'b0, 1'b1);
    load24(8'h10, 8'h00, 8'h0A);
    check_time24("t5_sec_digit", 8'h14, 8'h30, 8'h00, 1'b0, 1'b0, 1'b1);
    cd = 1'b1;
    repeat (3) step();
    load24(8'h12, 8'h34, 8'h56);
    check_time24("t5_coincident", 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 1'b0);
    step();
    check_time24("t5_discarded", 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 1'b0);
    fall();

    // T6: enable low freezes time; re-enable while high gives no tick
    if24.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rise();
      check_time24("t6_frozen", 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 1'b0);
      fall();
    end
    rise();
    if24.enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_val("t6_reenable_tick", {7'd0, if24.sec_tick}, 8'h00);
    end
    check_val("t6_reenable_sec", if24.sec, 8'h56);
    fall();
    rise();
    check_time24("t6_next_edge", 8'h12, 8'h34, 8'h57, 1'b1, 1'b0, 1'b0);
    fall();

    // Reset mid-count drops the in-flight edge
    cd = 1'b1;
    repeat (2) step();
    cd  = 1'b0;
    rst = 1'b1;
    step();
    check_time24("rst_mid", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("rst_mid_tick", {7'd0, if24.sec_tick}, 8'h00);
    end
    check_time24("rst_mid_end", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
